// File: rtl/csr_file_m.sv
`default_nettype none
// ============================================================================
// csr_file_m : machine-mode CSR file (RW/RS/RC, counters, timer, trap/MRET, fflags)
// Revision   : 1.0
// ============================================================================
module csr_file_m #(
  parameter int          XLEN      = 32,
  parameter int          CNT_WIDTH = 64,
  parameter int          TIMER_DIV = 1,
  parameter logic [31:0] HART_ID   = 32'd0
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            req_valid,
  input  logic [1:0]      req_op,
  input  logic [11:0]     req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            rsp_valid,
  output logic [XLEN-1:0] rsp_rdata,
  output logic            rsp_illegal,
  input  logic            retire,
  input  logic            trap_en,
  input  logic [XLEN-1:0] trap_cause,
  input  logic [XLEN-1:0] trap_pc,
  input  logic [XLEN-1:0] trap_tval,
  input  logic            mret_en,
  input  logic            ext_irq,
  input  logic            fflags_valid,
  input  logic [4:0]      fflags_in,
  output logic [XLEN-1:0] mtvec_o,
  output logic [XLEN-1:0] mepc_o,
  output logic [2:0]      frm_o,
  output logic            irq_pending,
  output logic [XLEN-1:0] irq_cause
);

  localparam int PW = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;

  localparam logic [11:0] ADDR_FFLAGS    = 12'h001;
  localparam logic [11:0] ADDR_FRM       = 12'h002;
  localparam logic [11:0] ADDR_FCSR      = 12'h003;
  localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
  localparam logic [11:0] ADDR_MISA      = 12'h301;
  localparam logic [11:0] ADDR_MIE       = 12'h304;
  localparam logic [11:0] ADDR_MTVEC     = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH  = 12'h340;
  localparam logic [11:0] ADDR_MEPC      = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
  localparam logic [11:0] ADDR_MTVAL     = 12'h343;
  localparam logic [11:0] ADDR_MIP       = 12'h344;
  localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
  localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
  localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;
  localparam logic [11:0] ADDR_CYCLE     = 12'hC00;
  localparam logic [11:0] ADDR_CYCLEH    = 12'hC80;
  localparam logic [11:0] ADDR_INSTRET   = 12'hC02;
  localparam logic [11:0] ADDR_INSTRETH  = 12'hC82;
  localparam logic [11:0] ADDR_MTIMECMP  = 12'h7C0;
  localparam logic [11:0] ADDR_MTIMECMPH = 12'h7C1;
  localparam logic [11:0] ADDR_MHARTID   = 12'hF14;

  logic [4:0]           fflags_q,   fflags_d;
  logic [2:0]           frm_q,      frm_d;
  logic                 mie_q,      mie_d;
  logic                 mpie_q,     mpie_d;
  logic                 meie_q,     meie_d;
  logic                 mtie_q,     mtie_d;
  logic                 meip_q,     meip_d;
  logic                 mtip_q,     mtip_d;
  logic [XLEN-1:0]      mtvec_q,    mtvec_d;
  logic [XLEN-1:0]      mscratch_q, mscratch_d;
  logic [XLEN-1:0]      mepc_q,     mepc_d;
  logic [XLEN-1:0]      mcause_q,   mcause_d;
  logic [XLEN-1:0]      mtval_q,    mtval_d;
  logic [CNT_WIDTH-1:0] mcycle_q,   mcycle_d;
  logic [CNT_WIDTH-1:0] minstret_q, minstret_d;
  logic [63:0]          mtimecmp_q, mtimecmp_d;
  logic [63:0]          mtime_q,    mtime_d;
  logic [PW-1:0]        presc_q,    presc_d;
  logic                 rsp_valid_q,   rsp_valid_d;
  logic [XLEN-1:0]      rsp_rdata_q,   rsp_rdata_d;
  logic                 rsp_illegal_q, rsp_illegal_d;

  logic [63:0]     mcycle_ext;
  logic [63:0]     minstret_ext;
  logic [XLEN-1:0] rd_val;
  logic [XLEN-1:0] wval;
  logic [4:0]      ff_acc;
  logic            mapped;
  logic            read_only;
  logic            wr_attempt;
  logic            illegal;
  logic            csr_we;
  logic            presc_wrap;

  assign mcycle_ext   = 64'(mcycle_q);
  assign minstret_ext = 64'(minstret_q);
  assign presc_wrap   = (presc_q == PW'(TIMER_DIV - 1));
  assign ff_acc       = fflags_valid ? fflags_in : 5'd0;

  always_comb begin
    rd_val = '0;
    mapped = 1'b1;
    case (req_addr)
      ADDR_FFLAGS:                   rd_val[4:0] = fflags_q;
      ADDR_FRM:                      rd_val[2:0] = frm_q;
      ADDR_FCSR:                     rd_val[7:0] = {frm_q, fflags_q};
      ADDR_MSTATUS: begin
        rd_val[7] = mpie_q;
        rd_val[3] = mie_q;
      end
      ADDR_MISA:                     rd_val = 32'h4000_1100;
      ADDR_MIE: begin
        rd_val[11] = meie_q;
        rd_val[7]  = mtie_q;
      end
      ADDR_MTVEC:                    rd_val = mtvec_q;
      ADDR_MSCRATCH:                 rd_val = mscratch_q;
      ADDR_MEPC:                     rd_val = mepc_q;
      ADDR_MCAUSE:                   rd_val = mcause_q;
      ADDR_MTVAL:                    rd_val = mtval_q;
      ADDR_MIP: begin
        rd_val[11] = meip_q;
        rd_val[7]  = mtip_q;
      end
      ADDR_MCYCLE,   ADDR_CYCLE:     rd_val = mcycle_ext[31:0];
      ADDR_MCYCLEH,  ADDR_CYCLEH:    rd_val = mcycle_ext[63:32];
      ADDR_MINSTRET, ADDR_INSTRET:   rd_val = minstret_ext[31:0];
      ADDR_MINSTRETH, ADDR_INSTRETH: rd_val = minstret_ext[63:32];
      ADDR_MTIMECMP:                 rd_val = mtimecmp_q[31:0];
      ADDR_MTIMECMPH:                rd_val = mtimecmp_q[63:32];
      ADDR_MHARTID:                  rd_val = HART_ID;
      default:                       mapped = 1'b0;
    endcase
  end

  // RS/RC with a zero mask are pure reads, so they stay legal on read-only CSRs.
  assign read_only  = (req_addr[11:10] == 2'b11) || (req_addr == ADDR_MISA) || (req_addr == ADDR_MIP);
  assign wr_attempt = (req_op == 2'b01) || (req_op[1] && (req_wdata != '0));
  assign illegal    = req_valid && (!mapped || (read_only && wr_attempt));
  assign csr_we     = req_valid && !illegal && wr_attempt && !trap_en && !mret_en;

  always_comb begin
    case (req_op)
      2'b01:   wval = req_wdata;
      2'b10:   wval = rd_val | req_wdata;
      2'b11:   wval = rd_val & ~req_wdata;
      default: wval = rd_val;
    endcase
  end

  always_comb begin
    fflags_d   = fflags_q | ff_acc;
    frm_d      = frm_q;
    mie_d      = mie_q;
    mpie_d     = mpie_q;
    meie_d     = meie_q;
    mtie_d     = mtie_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    mtval_d    = mtval_q;
    mtimecmp_d = mtimecmp_q;
    mcycle_d   = mcycle_q + CNT_WIDTH'(1);
    minstret_d = retire ? minstret_q + CNT_WIDTH'(1) : minstret_q;
    presc_d    = presc_wrap ? '0 : presc_q + PW'(1);
    mtime_d    = presc_wrap ? mtime_q + 64'd1 : mtime_q;
    mtip_d     = (mtime_q >= mtimecmp_q);
    meip_d     = ext_irq;

    if (trap_en) begin
      mepc_d   = trap_pc & ~32'h3;
      mcause_d = trap_cause;
      mtval_d  = trap_tval;
      mpie_d   = mie_q;
      mie_d    = 1'b0;
    end else if (mret_en) begin
      mie_d  = mpie_q;
      mpie_d = 1'b1;
    end else if (csr_we) begin
      case (req_addr)
        ADDR_FFLAGS:    fflags_d = wval[4:0] | ff_acc;
        ADDR_FRM:       frm_d    = wval[2:0];
        ADDR_FCSR: begin
          frm_d    = wval[7:5];
          fflags_d = wval[4:0] | ff_acc;
        end
        ADDR_MSTATUS: begin
          mie_d  = wval[3];
          mpie_d = wval[7];
        end
        ADDR_MIE: begin
          meie_d = wval[11];
          mtie_d = wval[7];
        end
        ADDR_MTVEC:     mtvec_d    = wval & ~32'h3;
        ADDR_MSCRATCH:  mscratch_d = wval;
        ADDR_MEPC:      mepc_d     = wval & ~32'h3;
        ADDR_MCAUSE:    mcause_d   = wval;
        ADDR_MTVAL:     mtval_d    = wval;
        // Counter writes replace this cycle's increment; bits above CNT_WIDTH drop off.
        ADDR_MCYCLE:    mcycle_d   = CNT_WIDTH'({mcycle_ext[63:32], wval});
        ADDR_MCYCLEH:   mcycle_d   = CNT_WIDTH'({wval, mcycle_ext[31:0]});
        ADDR_MINSTRET:  minstret_d = CNT_WIDTH'({minstret_ext[63:32], wval});
        ADDR_MINSTRETH: minstret_d = CNT_WIDTH'({wval, minstret_ext[31:0]});
        ADDR_MTIMECMP:  mtimecmp_d = {mtimecmp_q[63:32], wval};
        ADDR_MTIMECMPH: mtimecmp_d = {wval, mtimecmp_q[31:0]};
        default: ;
      endcase
    end
  end

  always_comb begin
    rsp_valid_d   = req_valid;
    rsp_illegal_d = illegal;
    rsp_rdata_d   = (req_valid && !illegal) ? rd_val : '0;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      fflags_q      <= '0;
      frm_q         <= '0;
      mie_q         <= 1'b0;
      mpie_q        <= 1'b0;
      meie_q        <= 1'b0;
      mtie_q        <= 1'b0;
      meip_q        <= 1'b0;
      mtip_q        <= 1'b0;
      mtvec_q       <= '0;
      mscratch_q    <= '0;
      mepc_q        <= '0;
      mcause_q      <= '0;
      mtval_q       <= '0;
      mcycle_q      <= '0;
      minstret_q    <= '0;
      mtimecmp_q    <= '1;
      mtime_q       <= '0;
      presc_q       <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_illegal_q <= 1'b0;
    end else begin
      fflags_q      <= fflags_d;
      frm_q         <= frm_d;
      mie_q         <= mie_d;
      mpie_q        <= mpie_d;
      meie_q        <= meie_d;
      mtie_q        <= mtie_d;
      meip_q        <= meip_d;
      mtip_q        <= mtip_d;
      mtvec_q       <= mtvec_d;
      mscratch_q    <= mscratch_d;
      mepc_q        <= mepc_d;
      mcause_q      <= mcause_d;
      mtval_q       <= mtval_d;
      mcycle_q      <= mcycle_d;
      minstret_q    <= minstret_d;
      mtimecmp_q    <= mtimecmp_d;
      mtime_q       <= mtime_d;
      presc_q       <= presc_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_illegal_q <= rsp_illegal_d;
    end
  end

  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_illegal = rsp_illegal_q;
  assign mtvec_o     = mtvec_q;
  assign mepc_o      = mepc_q;
  assign frm_o       = frm_q;
  assign irq_pending = mie_q && ((meie_q && meip_q) || (mtie_q && mtip_q));
  assign irq_cause   = (meie_q && meip_q) ? 32'h8000_000B : 32'h8000_0007;

endmodule

`default_nettype wire

// File: tb/tb_csr_file_m.sv
`default_nettype none
// ============================================================================
// tb_csr_file_m : self-checking bench for csr_file_m against a behavioural CSR model
// Revision      : 1.0
// ============================================================================
module tb_csr_file_m;

  localparam int          CW    = 40;
  localparam int          TDIV  = 4;
  localparam logic [31:0] HID   = 32'h5;
  localparam logic [63:0] CMASK = (64'd1 << CW) - 64'd1;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        req_valid = 1'b0;
  logic [1:0]  req_op = 2'b00;
  logic [11:0] req_addr = 12'h000;
  logic [31:0] req_wdata = 32'h0;
  logic        retire = 1'b0;
  logic        trap_en = 1'b0;
  logic [31:0] trap_cause = 32'h0;
  logic [31:0] trap_pc = 32'h0;
  logic [31:0] trap_tval = 32'h0;
  logic        mret_en = 1'b0;
  logic        ext_irq = 1'b0;
  logic        fflags_valid = 1'b0;
  logic [4:0]  fflags_in = 5'h0;
  logic        rsp_valid, rsp_illegal, irq_pending;
  logic [31:0] rsp_rdata, mtvec_o, mepc_o, irq_cause;
  logic [2:0]  frm_o;
  logic [133:0] dut_outs;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  csr_file_m #(.XLEN(32), .CNT_WIDTH(CW), .TIMER_DIV(TDIV), .HART_ID(HID)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_illegal(rsp_illegal),
    .retire(retire), .trap_en(trap_en), .trap_cause(trap_cause), .trap_pc(trap_pc),
    .trap_tval(trap_tval), .mret_en(mret_en), .ext_irq(ext_irq),
    .fflags_valid(fflags_valid), .fflags_in(fflags_in),
    .mtvec_o(mtvec_o), .mepc_o(mepc_o), .frm_o(frm_o),
    .irq_pending(irq_pending), .irq_cause(irq_cause)
  );

  assign dut_outs = {rsp_valid, rsp_rdata, rsp_illegal, mtvec_o, mepc_o, frm_o, irq_pending, irq_cause};

  // Reference model: architectural CSR state, mtime derived from elapsed cycles.
  logic [4:0]  m_fflags;
  logic [2:0]  m_frm;
  logic        m_mie, m_mpie, m_meie, m_mtie, m_meip, m_mtip;
  logic [31:0] m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval;
  logic [63:0] m_mcycle, m_minstret, m_mtimecmp, m_ticks;
  logic        m_rsp_valid, m_rsp_ill;
  logic [31:0] m_rsp_rdata;

  function automatic void m_read(input logic [11:0] a, output bit mp, output bit ro, output logic [31:0] v);
    mp = 1'b1;
    v  = 32'h0;
    ro = (a[11:10] == 2'b11) || (a == 12'h301) || (a == 12'h344);
    case (a)
      12'h001: v = {27'h0, m_fflags};
      12'h002: v = {29'h0, m_frm};
      12'h003: v = {24'h0, m_frm, m_fflags};
      12'h300: v = (m_mpie ? 32'h80 : 32'h0) | (m_mie ? 32'h8 : 32'h0);
      12'h301: v = 32'h4000_1100;
      12'h304: v = (m_meie ? 32'h800 : 32'h0) | (m_mtie ? 32'h80 : 32'h0);
      12'h305: v = m_mtvec;
      12'h340: v = m_mscratch;
      12'h341: v = m_mepc;
      12'h342: v = m_mcause;
      12'h343: v = m_mtval;
      12'h344: v = (m_meip ? 32'h800 : 32'h0) | (m_mtip ? 32'h80 : 32'h0);
      12'hB00, 12'hC00: v = m_mcycle[31:0];
      12'hB80, 12'hC80: v = m_mcycle[63:32];
      12'hB02, 12'hC02: v = m_minstret[31:0];
      12'hB82, 12'hC82: v = m_minstret[63:32];
      12'h7C0: v = m_mtimecmp[31:0];
      12'h7C1: v = m_mtimecmp[63:32];
      12'hF14: v = HID;
      default: mp = 1'b0;
    endcase
  endfunction

  function automatic logic [133:0] m_outs();
    logic pend;
    pend = m_mie && ((m_meie && m_meip) || (m_mtie && m_mtip));
    return {m_rsp_valid, m_rsp_rdata, m_rsp_ill, m_mtvec, m_mepc, m_frm, pend,
            (m_meie && m_meip) ? 32'h8000_000B : 32'h8000_0007};
  endfunction

  task automatic model_step();
    bit          mp, ro, wr, ill, we;
    logic [31:0] v, wv;
    logic [63:0] c_old, i_old;
    logic [4:0]  acc;
    if (!resetn) begin
      m_fflags = 0; m_frm = 0; m_mie = 0; m_mpie = 0; m_meie = 0; m_mtie = 0;
      m_meip = 0; m_mtip = 0; m_mtvec = 0; m_mscratch = 0; m_mepc = 0;
      m_mcause = 0; m_mtval = 0; m_mcycle = 0; m_minstret = 0;
      m_mtimecmp = '1; m_ticks = 0;
      m_rsp_valid = 0; m_rsp_rdata = 0; m_rsp_ill = 0;
      return;
    end
    m_read(req_addr, mp, ro, v);
    wr  = (req_op == 2'b01) || (req_op >= 2'b10 && req_wdata != 32'h0);
    ill = req_valid && (!mp || (ro && wr));
    we  = req_valid && !ill && wr && !trap_en && !mret_en;
    case (req_op)
      2'b01:   wv = req_wdata;
      2'b10:   wv = v | req_wdata;
      default: wv = v & ~req_wdata;
    endcase
    m_rsp_valid = req_valid;
    m_rsp_ill   = ill;
    m_rsp_rdata = (req_valid && !ill) ? v : 32'h0;
    m_mtip  = ((m_ticks / TDIV) >= m_mtimecmp);
    m_ticks = m_ticks + 1;
    m_meip  = ext_irq;
    c_old = m_mcycle;
    i_old = m_minstret;
    m_mcycle = (m_mcycle + 1) & CMASK;
    if (retire) m_minstret = (m_minstret + 1) & CMASK;
    acc = fflags_valid ? fflags_in : 5'h0;
    m_fflags = m_fflags | acc;
    if (trap_en) begin
      m_mepc = trap_pc & ~32'h3; m_mcause = trap_cause; m_mtval = trap_tval;
      m_mpie = m_mie; m_mie = 1'b0;
    end else if (mret_en) begin
      m_mie = m_mpie; m_mpie = 1'b1;
    end else if (we) begin
      case (req_addr)
        12'h001: m_fflags = wv[4:0] | acc;
        12'h002: m_frm = wv[2:0];
        12'h003: begin m_frm = wv[7:5]; m_fflags = wv[4:0] | acc; end
        12'h300: begin m_mie = wv[3]; m_mpie = wv[7]; end
        12'h304: begin m_meie = wv[11]; m_mtie = wv[7]; end
        12'h305: m_mtvec = wv & ~32'h3;
        12'h340: m_mscratch = wv;
        12'h341: m_mepc = wv & ~32'h3;
        12'h342: m_mcause = wv;
        12'h343: m_mtval = wv;
        12'hB00: m_mcycle = {c_old[63:32], wv} & CMASK;
        12'hB80: m_mcycle = {wv, c_old[31:0]} & CMASK;
        12'hB02: m_minstret = {i_old[63:32], wv} & CMASK;
        12'hB82: m_minstret = {wv, i_old[31:0]} & CMASK;
        12'h7C0: m_mtimecmp[31:0] = wv;
        12'h7C1: m_mtimecmp[63:32] = wv;
        default: ;
      endcase
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic csr_req(input logic [1:0] op, input logic [11:0] a, input logic [31:0] d);
    req_valid = 1'b1; req_op = op; req_addr = a; req_wdata = d;
    tick();
    req_valid = 1'b0; req_op = 2'b00; req_wdata = 32'h0;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    logic [133:0] exp_rst;
    exp_rst = {1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 3'h0, 1'b0, 32'h8000_0007};
    resetn = 1'b0;
    req_valid = 1'b1; req_op = 2'b01; req_addr = 12'h340; req_wdata = 32'h1234;
    tick();
    tick();
    req_valid = 1'b0; req_op = 2'b00; req_wdata = 32'h0;
    n_checks++;
    if (dut_outs !== exp_rst) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h required %h", dut_outs, exp_rst);
    end
    resetn = 1'b1;
    csr_req(2'b00, 12'h340, 32'h0);
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_drops_write: valid=%b rdata=%h required 1/00000000", rsp_valid, rsp_rdata);
    end
  endtask

  task automatic test_rw_set_clear();
    csr_req(2'b01, 12'h340, 32'hDEADBEEF);
    csr_req(2'b10, 12'h340, 32'h10);
    n_checks++;
    if (rsp_rdata !== 32'hDEADBEEF || rsp_illegal !== 1'b0) begin
      n_fail++; $display("FAIL rs_old: got %h required DEADBEEF", rsp_rdata);
    end
    csr_req(2'b11, 12'h340, 32'hF);
    n_checks++;
    if (rsp_rdata !== 32'hDEADBEFF) begin
      n_fail++; $display("FAIL rc_old: got %h required DEADBEFF", rsp_rdata);
    end
    csr_req(2'b00, 12'h340, 32'h0);
    n_checks++;
    if (rsp_rdata !== 32'hDEADBEF0 || rsp_valid !== 1'b1) begin
      n_fail++; $display("FAIL rc_result: got %h required DEADBEF0", rsp_rdata);
    end
  endtask

  task automatic test_illegal();
    logic [11:0] bad_a [0:3];
    logic [1:0]  bad_op [0:3];
    bad_a  = '{12'hC00, 12'h344, 12'h123, 12'h301};
    bad_op = '{2'b01,   2'b01,   2'b00,   2'b10};
    for (int i = 0; i < 4; i++) begin
      csr_req(bad_op[i], bad_a[i], 32'hFFFF_FFFF);
      n_checks++;
      if (rsp_illegal !== 1'b1 || rsp_rdata !== 32'h0 || rsp_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL illegal_%h: illegal=%b rdata=%h required 1/00000000", bad_a[i], rsp_illegal, rsp_rdata);
      end
    end
    csr_req(2'b00, 12'h301, 32'h0);
    n_checks++;
    if (rsp_illegal !== 1'b0 || rsp_rdata !== 32'h4000_1100) begin
      n_fail++; $display("FAIL misa_read: got %h required 40001100", rsp_rdata);
    end
    csr_req(2'b00, 12'h344, 32'h0);
    n_checks++;
    if (rsp_rdata !== 32'h0) begin
      n_fail++; $display("FAIL mip_unchanged: got %h required 00000000", rsp_rdata);
    end
    csr_req(2'b10, 12'hC00, 32'h0);
    n_checks++;
    if (rsp_illegal !== 1'b0 || rsp_rdata !== m_rsp_rdata) begin
      n_fail++; $display("FAIL cycle_rs0: illegal=%b rdata=%h required 0/%h", rsp_illegal, rsp_rdata, m_rsp_rdata);
    end
    csr_req(2'b11, 12'hF14, 32'h0);
    n_checks++;
    if (rsp_illegal !== 1'b0 || rsp_rdata !== HID) begin
      n_fail++; $display("FAIL mhartid: got %h required %h", rsp_rdata, HID);
    end
  endtask

  task automatic test_timer();
    int rise;
    rise = -1;
    do_reset();
    csr_req(2'b01, 12'h7C0, 32'd10);
    csr_req(2'b01, 12'h7C1, 32'd0);
    csr_req(2'b01, 12'h304, 32'h80);
    csr_req(2'b01, 12'h300, 32'h8);
    for (int i = 0; i < 60; i++) begin
      tick();
      n_checks++;
      if (dut_outs !== m_outs()) begin
        n_fail++; $display("FAIL timer_cycle%0d: got %h required %h", i, dut_outs, m_outs());
      end
      if (irq_pending === 1'b1 && rise < 0) rise = int'(m_ticks);
    end
    n_checks++;
    if (rise < 41 || rise > 42) begin
      n_fail++; $display("FAIL timer_rise: rose at cycle %0d required 41..42", rise);
    end
    n_checks++;
    if (irq_cause !== 32'h8000_0007) begin
      n_fail++; $display("FAIL timer_cause: got %h required 80000007", irq_cause);
    end
    csr_req(2'b01, 12'h304, 32'h0);
  endtask

  task automatic test_trap();
    csr_req(2'b01, 12'h300, 32'h8);
    csr_req(2'b01, 12'h340, 32'hCAFE_0001);
    trap_en = 1'b1; trap_pc = 32'h103; trap_cause = 32'h2; trap_tval = 32'h55;
    csr_req(2'b01, 12'h340, 32'h1234_5678);
    trap_en = 1'b0;
    n_checks++;
    if (rsp_illegal !== 1'b0 || rsp_rdata !== 32'hCAFE_0001 || mepc_o !== 32'h100) begin
      n_fail++;
      $display("FAIL trap_entry: illegal=%b rdata=%h mepc=%h required 0/CAFE0001/00000100", rsp_illegal, rsp_rdata, mepc_o);
    end
    csr_req(2'b00, 12'h300, 32'h0);
    n_checks++;
    if (rsp_rdata !== 32'h80) begin
      n_fail++; $display("FAIL trap_mstatus: got %h required 00000080", rsp_rdata);
    end
    csr_req(2'b00, 12'h342, 32'h0);
    n_checks++;
    if (rsp_rdata !== 32'h2) begin
      n_fail++; $display("FAIL trap_mcause: got %h required 00000002", rsp_rdata);
    end
    csr_req(2'b00, 12'h343, 32'h0);
    n_checks++;
    if (rsp_rdata !== 32'h55) begin
      n_fail++; $display("FAIL trap_mtval: got %h required 00000055", rsp_rdata);
    end
    csr_req(2'b00, 12'h340, 32'h0);
    n_checks++;
    if (rsp_rdata !== 32'hCAFE_0001) begin
      n_fail++; $display("FAIL trap_write_dropped: got %h required CAFE0001", rsp_rdata);
    end
    mret_en = 1'b1;
    csr_req(2'b01, 12'h300, 32'h0);
    mret_en = 1'b0;
    csr_req(2'b00, 12'h300, 32'h0);
    n_checks++;
    if (rsp_rdata !== 32'h88) begin
      n_fail++; $display("FAIL mret_mstatus: got %h required 00000088", rsp_rdata);
    end
  endtask

  task automatic test_counters();
    csr_req(2'b01, 12'hB80, 32'hFF);
    csr_req(2'b01, 12'hB00, 32'hFFFF_FFFF);
    tick();
    csr_req(2'b00, 12'hB00, 32'h0);
    n_checks++;
    if (rsp_rdata !== 32'h0) begin
      n_fail++; $display("FAIL mcycle_wrap_lo: got %h required 00000000", rsp_rdata);
    end
    csr_req(2'b00, 12'hB80, 32'h0);
    n_checks++;
    if (rsp_rdata !== 32'h0) begin
      n_fail++; $display("FAIL mcycle_wrap_hi: got %h required 00000000", rsp_rdata);
    end
    csr_req(2'b01, 12'hB80, 32'hFFFF);
    csr_req(2'b00, 12'hB80, 32'h0);
    n_checks++;
    if (rsp_rdata !== 32'hFF) begin
      n_fail++; $display("FAIL mcycle_hi_trunc: got %h required 000000FF", rsp_rdata);
    end
    csr_req(2'b01, 12'hB02, 32'h100);
    retire = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    retire = 1'b0;
    csr_req(2'b00, 12'hC02, 32'h0);
    n_checks++;
    if (rsp_rdata !== 32'h103) begin
      n_fail++; $display("FAIL minstret_retire3: got %h required 00000103", rsp_rdata);
    end
    retire = 1'b1;
    csr_req(2'b01, 12'hB02, 32'h200);
    retire = 1'b0;
    csr_req(2'b00, 12'hB02, 32'h0);
    n_checks++;
    if (rsp_rdata !== 32'h200) begin
      n_fail++; $display("FAIL minstret_write_wins: got %h required 00000200", rsp_rdata);
    end
    csr_req(2'b01, 12'hB82, 32'hFF);
    csr_req(2'b01, 12'hB02, 32'hFFFF_FFFF);
    retire = 1'b1;
    tick();
    retire = 1'b0;
    csr_req(2'b00, 12'hB02, 32'h0);
    n_checks++;
    if (rsp_rdata !== 32'h0) begin
      n_fail++; $display("FAIL minstret_wrap_lo: got %h required 00000000", rsp_rdata);
    end
    csr_req(2'b00, 12'hB82, 32'h0);
    n_checks++;
    if (rsp_rdata !== 32'h0) begin
      n_fail++; $display("FAIL minstret_wrap_hi: got %h required 00000000", rsp_rdata);
    end
  endtask

  task automatic test_fflags();
    csr_req(2'b01, 12'h003, 32'h0);
    fflags_valid = 1'b1; fflags_in = 5'h01;
    tick();
    fflags_in = 5'h04;
    tick();
    fflags_valid = 1'b0; fflags_in = 5'h0;
    csr_req(2'b00, 12'h001, 32'h0);
    n_checks++;
    if (rsp_rdata !== 32'h05) begin
      n_fail++; $display("FAIL fflags_accum: got %h required 00000005", rsp_rdata);
    end
    fflags_valid = 1'b1; fflags_in = 5'h08;
    csr_req(2'b01, 12'h003, 32'hE2);
    fflags_valid = 1'b0; fflags_in = 5'h0;
    n_checks++;
    if (frm_o !== 3'b111) begin
      n_fail++; $display("FAIL frm_o: got %b required 111", frm_o);
    end
    csr_req(2'b00, 12'h003, 32'h0);
    n_checks++;
    if (rsp_rdata !== 32'hEA) begin
      n_fail++; $display("FAIL fcsr_merge: got %h required 000000EA", rsp_rdata);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] prev, d;
    csr_req(2'b01, 12'h341, 32'h0);
    prev = 32'h0;
    req_valid = 1'b1; req_op = 2'b01; req_addr = 12'h341;
    for (int i = 0; i < 8; i++) begin
      d = $urandom;
      req_wdata = d;
      tick();
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== prev || mepc_o !== (d & ~32'h3)) begin
        n_fail++;
        $display("FAIL b2b_%0d: rdata=%h mepc=%h required %h/%h", i, rsp_rdata, mepc_o, prev, d & ~32'h3);
      end
      prev = d & ~32'h3;
    end
    req_valid = 1'b0; req_op = 2'b00; req_wdata = 32'h0;
  endtask

  task automatic test_random();
    logic [11:0] addrs [0:24];
    addrs = '{12'h001, 12'h002, 12'h003, 12'h300, 12'h301, 12'h304, 12'h305, 12'h340,
              12'h341, 12'h342, 12'h343, 12'h344, 12'hB00, 12'hB80, 12'hB02, 12'hB82,
              12'hC00, 12'hC80, 12'hC02, 12'hC82, 12'h7C0, 12'h7C1, 12'hF14, 12'h123, 12'h7FF};
    for (int i = 0; i < 400; i++) begin
      req_valid    = ($urandom_range(0, 3) != 0);
      req_op       = 2'($urandom_range(0, 3));
      req_addr     = addrs[$urandom_range(0, 24)];
      req_wdata    = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      retire       = 1'($urandom_range(0, 1));
      trap_en      = ($urandom_range(0, 15) == 0);
      mret_en      = ($urandom_range(0, 15) == 0);
      trap_pc      = $urandom;
      trap_cause   = $urandom;
      trap_tval    = $urandom;
      fflags_valid = 1'($urandom_range(0, 1));
      fflags_in    = 5'($urandom);
      if ($urandom_range(0, 7) == 0) ext_irq = ~ext_irq;
      tick();
      n_checks++;
      if (dut_outs !== m_outs()) begin
        n_fail++; $display("FAIL random_%0d: got %h required %h", i, dut_outs, m_outs());
      end
    end
    req_valid = 1'b0; req_op = 2'b00; req_wdata = 32'h0; retire = 1'b0;
    trap_en = 1'b0; mret_en = 1'b0; fflags_valid = 1'b0; ext_irq = 1'b0;
  endtask

  initial begin
    test_reset();
    test_rw_set_clear();
    test_illegal();
    test_timer();
    test_trap();
    test_counters();
    test_fflags();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
